// File: rtl/tdc_chan_burst_buf.sv
// Per-channel TDC timestamp FIFO that requests the arbiter and emits one enable-framed burst per grant.
// Optional build macro TDC_BUF_HEADER_EN prefixes each burst with a {4'hA, CHAN_ID, n} header word.
module tdc_chan_burst_buf #(
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 64,
   parameter int BURST_LEN     = 16,
   parameter int FLUSH_TIMEOUT = 1024,
   parameter int MIN_GAP       = 2,
   parameter int CHAN_ID       = 0
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic                      i_wr_en,
   input  logic [DATA_WIDTH-1:0]     i_wr_data,
   input  logic                      i_flush,
   input  logic                      i_grant,
   output logic                      o_req,
   output logic                      o_en,
   output logic [DATA_WIDTH-1:0]     o_data,
   output logic [$clog2(DEPTH):0]    o_level,
   output logic                      o_full,
   output logic [15:0]               o_ovf_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int NW = $clog2(BURST_LEN + 1);
   localparam int TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND, S_GAP} state_e;

   function automatic logic [DATA_WIDTH-1:0] hdr_word(input logic [NW-1:0] n);
      logic [DATA_WIDTH-1:0] w;
      w                    = '0;
      w[DATA_WIDTH-1 -: 4] = 4'hA;
      w[15:8]              = 8'(CHAN_ID);
      w[7:0]               = 8'(n);
      return w;
   endfunction

   state_e                  state_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]           count_q, count_d;
   logic                    full_q;
   logic [15:0]             ovf_q, ovf_d;
   logic [TW-1:0]           to_q, to_d;
   logic                    flush_pend_q;
   logic                    req_q;
   logic                    en_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [NW-1:0]           rem_q;
   logic [GW-1:0]           gap_q;

   logic                    wr_acc_s;
   logic                    rd_s;
   logic                    to_hit_s;
   logic                    trig_s;
   logic [NW-1:0]           n_s;

   // FIFO bookkeeping, timeout counter and burst trigger
   always_comb begin
      wr_acc_s = i_wr_en && !full_q;
`ifdef TDC_BUF_HEADER_EN
      rd_s = (state_q == S_SEND) && (rem_q != '0);
`else
      rd_s = ((state_q == S_REQ) && i_grant) || ((state_q == S_SEND) && (rem_q != '0));
`endif
      if (wr_acc_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (rd_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_s})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase
      // A write that finds the FIFO full is lost even if a read frees a slot this cycle
      if (i_wr_en && full_q && (ovf_q != 16'hFFFF)) begin
         ovf_d = ovf_q + 16'd1;
      end else begin
         ovf_d = ovf_q;
      end
      if (i_wr_en || (state_q != S_IDLE) || (count_q == '0)) begin
         to_d = '0;
      end else if ((FLUSH_TIMEOUT != 0) && (to_q != TW'(FLUSH_TIMEOUT))) begin
         to_d = to_q + TW'(1);
      end else begin
         to_d = to_q;
      end
      to_hit_s = (FLUSH_TIMEOUT != 0) && (to_q == TW'(FLUSH_TIMEOUT));
      trig_s   = (count_q >= LW'(BURST_LEN))
               || ((i_flush || flush_pend_q) && (count_q != '0))
               || to_hit_s;
      if (count_q >= LW'(BURST_LEN)) begin
         n_s = NW'(BURST_LEN);
      end else begin
         n_s = NW'(count_q);
      end
   end

   // Storage array; no reset needed since occupancy gates every read
   always_ff @(posedge sys_clk) begin
      if (wr_acc_s) begin
         mem_q[wr_ptr_q] <= i_wr_data;
      end
   end

   // Control FSM with registered request, framing and data outputs
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         ovf_q        <= '0;
         to_q         <= '0;
         flush_pend_q <= 1'b0;
         req_q        <= 1'b0;
         en_q         <= 1'b0;
         data_q       <= '0;
         rem_q        <= '0;
         gap_q        <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= (count_d == LW'(DEPTH));
         ovf_q    <= ovf_d;
         to_q     <= to_d;
         case (state_q)
            S_IDLE: begin
               en_q         <= 1'b0;
               data_q       <= '0;
               flush_pend_q <= 1'b0;
               if (trig_s) begin
                  req_q   <= 1'b1;
                  state_q <= S_REQ;
               end else begin
                  req_q   <= 1'b0;
               end
            end
            S_REQ: begin
               if (i_flush) begin
                  flush_pend_q <= 1'b1;
               end
               if (i_grant) begin
                  req_q   <= 1'b0;
                  en_q    <= 1'b1;
                  state_q <= S_SEND;
`ifdef TDC_BUF_HEADER_EN
                  data_q  <= hdr_word(n_s);
                  rem_q   <= n_s;
`else
                  data_q  <= mem_q[rd_ptr_q];
                  rem_q   <= n_s - NW'(1);
`endif
               end
            end
            S_SEND: begin
               if (i_flush) begin
                  flush_pend_q <= 1'b1;
               end
               if (rem_q != '0) begin
                  data_q <= mem_q[rd_ptr_q];
                  rem_q  <= rem_q - NW'(1);
               end else begin
                  en_q    <= 1'b0;
                  data_q  <= '0;
                  gap_q   <= GW'(MIN_GAP - 1);
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               if (i_flush) begin
                  flush_pend_q <= 1'b1;
               end
               if (gap_q == '0) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q - GW'(1);
               end
            end
            default: begin
               req_q   <= 1'b0;
               en_q    <= 1'b0;
               data_q  <= '0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign o_req     = req_q;
   assign o_en      = en_q;
   assign o_data    = data_q;
   assign o_level   = count_q;
   assign o_full    = full_q;
   assign o_ovf_cnt = ovf_q;

endmodule

// File: tb/tb_tdc_chan_burst_buf.sv
// Scoreboard bench for tdc_chan_burst_buf: stimulus queues expected words/burst lengths, a monitor checks bursts.
module tb_tdc_chan_burst_buf;

   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int BL    = 16;
   localparam int TO    = 1024;
   localparam int GAP   = 2;
   localparam int CHAN  = 1;
`ifdef TDC_BUF_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          flush;
   logic          grant_man;
   logic          grant_tie;
   logic          grant;
   logic          o_req;
   logic          o_en;
   logic [DW-1:0] o_data;
   logic [6:0]    o_level;
   logic          o_full;
   logic [15:0]   o_ovf_cnt;

   assign grant = grant_tie ? o_req : grant_man;

   tdc_chan_burst_buf #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_LEN(BL),
      .FLUSH_TIMEOUT(TO), .MIN_GAP(GAP), .CHAN_ID(CHAN)
   ) dut (
      .sys_clk(clk), .sys_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
      .i_flush(flush), .i_grant(grant), .o_req(o_req), .o_en(o_en),
      .o_data(o_data), .o_level(o_level), .o_full(o_full), .o_ovf_cnt(o_ovf_cnt)
   );

   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   int            wr_cyc  = 0;
   int            fl_cyc  = 0;
   int            rise_cyc = 0;
   int            req_rise = 0;
   bit            mon_en  = 1'b1;
   logic [DW-1:0] exp_q[$];
   int            len_q[$];

   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm, input string msg);
      n_tests++;
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", nm, msg, cyc);
   endtask

   function automatic logic [DW-1:0] hdr_word(input int n);
      logic [DW-1:0] w;
      w            = '0;
      w[DW-1 -: 4] = 4'hA;
      w[15:8]      = 8'(CHAN);
      w[7:0]       = 8'(n);
      return w;
   endfunction

   // Monitor: pops expected burst lengths and data words whenever o_en frames a burst
   initial begin
      bit en_prev;
      bit req_prev;
      bit seen;
      int low_run;
      int words;
      int cur_n;
      en_prev = 0; req_prev = 0; seen = 0; low_run = 0; words = 0; cur_n = 0;
      forever begin
         @(negedge clk);
         if (rst || !mon_en) begin
            en_prev = 0; seen = 0; low_run = 0; req_prev = o_req;
         end else begin
            if (o_req && !req_prev) req_rise++;
            req_prev = o_req;
            if (o_en) begin
               if (!en_prev) begin
                  rise_cyc = cyc;
                  if (seen) begin
                     n_tests++;
                     if (low_run < GAP) begin
                        n_fail++;
                        $display("FAIL burst_gap: got %0d low cycles required >= %0d", low_run, GAP);
                     end
                  end
                  if (len_q.size() == 0) begin
                     fail_now("burst_unexpected", "o_en rose with no burst expected");
                     cur_n = 0;
                  end else begin
                     cur_n = len_q.pop_front();
                  end
                  words = 0;
               end
               if (HDR != 0 && words == 0) begin
                  chk("burst_header", o_data, hdr_word(cur_n));
               end else if (exp_q.size() == 0) begin
                  fail_now("burst_data", $sformatf("unexpected word 0x%0h", o_data));
               end else begin
                  chk("burst_data", o_data, exp_q.pop_front());
               end
               words++;
               low_run = 0;
            end else begin
               if (en_prev) begin
                  chk("burst_len", words, cur_n + HDR);
                  chk("data_idle_zero", o_data, 0);
                  seen = 1;
               end
               low_run++;
            end
            en_prev = o_en;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [DW-1:0] d, input bit stored);
      wr_en   = 1'b1;
      wr_data = d;
      if (stored) exp_q.push_back(d);
      step();
      wr_cyc = cyc;
      wr_en  = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      step();
      fl_cyc = cyc;
      flush  = 1'b0;
   endtask

   task automatic drain(input int budget, input string nm);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || len_q.size() != 0 || o_en) && k < budget) begin
         step();
         k++;
      end
      n_tests++;
      if (k >= budget) begin
         n_fail++;
         $display("FAIL %s: drain timeout, %0d words and %0d bursts still pending", nm, exp_q.size(), len_q.size());
      end
      repeat (4) step();
   endtask

   initial begin
      int k;
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0; grant_man = 1'b0; grant_tie = 1'b0;
      repeat (3) step();
      chk("rst_req", o_req, 0);
      chk("rst_en", o_en, 0);
      chk("rst_data", o_data, 0);
      chk("rst_level", o_level, 0);
      chk("rst_full", o_full, 0);
      chk("rst_ovf", o_ovf_cnt, 0);
      rst = 1'b0;
      step();

      // Full burst with grant tied to request
      grant_tie = 1'b1;
      req_rise  = 0;
      len_q.push_back(16);
      for (int i = 0; i < 16; i++) wr(32'h100 + 32'(i), 1'b1);
      @(negedge clk); chk("lat_req_early", o_req, 0);
      @(negedge clk); chk("lat_req_t2", o_req, 1);
      @(negedge clk); chk("lat_en_t3", o_en, 1);
      drain(100, "full_burst");
      chk("full_burst_req_pulses", req_rise, 1);
      chk("full_burst_level", o_level, 0);

      // Partial burst released by the idle timeout
      len_q.push_back(3);
      for (int i = 0; i < 3; i++) wr(32'h200 + 32'(i), 1'b1);
      drain(1200, "timeout_burst");
      chk("timeout_latency", rise_cyc - wr_cyc, 1026);

      // Partial burst released by flush after 10 idle cycles
      len_q.push_back(3);
      for (int i = 0; i < 3; i++) wr(32'h300 + 32'(i), 1'b1);
      repeat (10) step();
      pulse_flush();
      drain(100, "flush_burst");
      chk("flush_latency", rise_cyc - fl_cyc, 1);

      // Fill, overflow with grant held low, then release four bursts
      grant_tie = 1'b0;
      grant_man = 1'b0;
      for (int i = 0; i < 64; i++) wr(32'h400 + 32'(i), 1'b1);
      chk("fill_level", o_level, 64);
      chk("fill_full", o_full, 1);
      for (int i = 0; i < 5; i++) wr(32'hDEAD_0000 + 32'(i), 1'b0);
      chk("ovf_cnt", o_ovf_cnt, 5);
      chk("ovf_full", o_full, 1);
      chk("ovf_level", o_level, 64);
      chk("ovf_no_burst", o_en, 0);
      for (int i = 0; i < 4; i++) len_q.push_back(16);
      grant_tie = 1'b1;
      drain(300, "overflow_bursts");
      chk("overflow_level", o_level, 0);
      chk("overflow_full", o_full, 0);

      // Grant dropped mid-burst and writes during SEND go to the next burst
      grant_tie = 1'b0;
      grant_man = 1'b1;
      len_q.push_back(16);
      for (int i = 0; i < 16; i++) wr(32'h500 + 32'(i), 1'b1);
      k = 0;
      while (!o_en && k < 50) begin step(); k++; end
      if (k >= 50) fail_now("midburst_start", "burst never started");
      repeat (3) step();
      grant_man = 1'b0;
      len_q.push_back(4);
      for (int i = 0; i < 4; i++) wr(32'h600 + 32'(i), 1'b1);
      pulse_flush();
      chk("midburst_still_en", o_en, 1);
      grant_tie = 1'b1;
      drain(200, "midburst");

      // Reset during the 5th o_en cycle
      mon_en = 1'b0;
      for (int i = 0; i < 16; i++) wr(32'h700 + 32'(i), 1'b0);
      k = 0;
      while (!o_en && k < 50) begin step(); k++; end
      if (k >= 50) fail_now("rst_burst_start", "burst never started");
      repeat (4) step();
      chk("rst_mid_en_before", o_en, 1);
      rst = 1'b1;
      step();
      chk("rst_mid_en", o_en, 0);
      chk("rst_mid_level", o_level, 0);
      chk("rst_mid_req", o_req, 0);
      chk("rst_mid_ovf", o_ovf_cnt, 0);
      chk("rst_mid_data", o_data, 0);
      rst = 1'b0;
      exp_q.delete();
      len_q.delete();
      step();
      mon_en = 1'b1;
      repeat (20) step();
      chk("rst_no_resume", o_en, 0);

      // Normal operation after reset
      len_q.push_back(16);
      for (int i = 0; i < 16; i++) wr(32'h800 + 32'(i), 1'b1);
      drain(100, "post_rst_burst");
      chk("post_rst_level", o_level, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
